// File: rtl/fifo36_stream_reader_if.sv
// FIFO read port plus the downstream valid/ready stream of the FWFT reader.
interface fifo36_stream_reader_if;
  logic [35:0] readData;
  logic        empty;
  logic        readEnable;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
  logic        outLast;

  // master: the reader block itself
  modport master (
    input  readData, empty, outReady,
    output readEnable, outData, outValid, outLast
  );
  // slave: FIFO model / downstream consumer side
  modport slave (
    output readData, empty, outReady,
    input  readEnable, outData, outValid, outLast
  );
endinterface

// File: rtl/fifo36_stream_reader.sv
// Read-side consumer of the 36-bit FWFT FIFO: pops into a 2-entry skid buffer,
// checks per-byte parity, frames fixed-length packets, presents a valid/ready stream.
module fifo36_stream_reader #(
  parameter int PKT_LEN    = 16,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  fifo36_stream_reader_if.master bus,
  input  logic                 flush,
  input  logic                 clrErr,
  output logic                 parityErr,
  output logic [ERR_CNT_W-1:0] errCount
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } entry_t;

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);
  localparam logic        ODD      = (ODD_PARITY != 0);

  occ_t        occ;
  entry_t      head, tail;
  logic [15:0] cnt;
  logic [3:0]  mis;
  logic        pop, take, bad, pop_last;

  // Pop only with room in the skid buffer; gated by reset so nothing is lost while held
  assign pop      = resetN & !bus.empty & (occ != TWO) & !flush;
  assign take     = bus.outValid & bus.outReady;
  assign pop_last = (cnt == LAST_IDX);
  assign bad      = pop & (|mis);

  assign bus.readEnable = pop;
  assign bus.outValid   = (occ != EMPTY);
  assign bus.outData    = head.data;
  assign bus.outLast    = head.last;

  // Per-byte parity check of the FIFO head word
  always_comb begin
    mis = '0;
    for (int i = 0; i < 4; i++)
      mis[i] = bus.readData[32+i] ^ (^bus.readData[8*i +: 8]) ^ ODD;
  end

  // Skid-buffer occupancy FSM, head/tail storage and packet counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      occ  <= EMPTY;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      // a same-cycle take has already been seen downstream; just drop the rest
      occ <= EMPTY;
      cnt <= '0;
    end else begin
      if (pop) cnt <= pop_last ? 16'd0 : cnt + 16'd1;
      unique case (occ)
        EMPTY: if (pop) begin
          head <= '{data: bus.readData[31:0], last: pop_last};
          occ  <= ONE;
        end
        ONE: begin
          if (pop && !take) begin
            tail <= '{data: bus.readData[31:0], last: pop_last};
            occ  <= TWO;
          end else if (pop && take) begin
            head <= '{data: bus.readData[31:0], last: pop_last};
          end else if (take) begin
            occ <= EMPTY;
          end
        end
        TWO: if (take) begin
          head <= tail;
          occ  <= ONE;
        end
        default: occ <= EMPTY;
      endcase
    end
  end

  // Sticky parity flag and saturating error counter; a same-cycle error wins over clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      parityErr <= 1'b0;
      errCount  <= '0;
    end else if (clrErr) begin
      parityErr <= bad;
      errCount  <= bad ? ERR_CNT_W'(1) : '0;
    end else if (bad) begin
      parityErr <= 1'b1;
      if (errCount != '1) errCount <= errCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo36_stream_reader.sv
// Directed bench: FWFT FIFO model in memory, linear stimulus, immediate-assert checks.
module tb_fifo36_stream_reader;

  logic       clk = 1'b0;
  logic       resetN;
  logic       flush, clrErr;
  logic       parityErr;
  logic [7:0] errCount;

  fifo36_stream_reader_if bif ();

  fifo36_stream_reader #(.PKT_LEN(16), .ODD_PARITY(0), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .bus       (bif),
    .flush     (flush),
    .clrErr    (clrErr),
    .parityErr (parityErr),
    .errCount  (errCount)
  );

  always #5 clk = ~clk;

  logic [35:0] mem [0:511];
  int rd = 0, wr = 0;
  int ncmp = 0, nfail = 0;

  function automatic logic [31:0] dat(int k);
    return {16'(k) ^ 16'hA5C3, 16'(k)};
  endfunction

  function automatic logic [3:0] gp(logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  task automatic refresh();
    bif.readData = mem[rd[8:0]];
    bif.empty    = (rd == wr);
  endtask

  // push word k with parity bits XORed by flip (nonzero = corrupt)
  task automatic push(int k, logic [3:0] flip);
    logic [31:0] d;
    d = dat(k);
    mem[wr[8:0]] = {gp(d) ^ flip, d};
    wr++;
    refresh();
  endtask

  // one clock: sample the pop strobe before the edge, advance the FIFO model after it
  task automatic tick();
    logic p;
    #2;
    p = bif.readEnable;
    @(posedge clk);
    #1;
    if (p) rd++;
    refresh();
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetN = 1'b0; flush = 1'b0; clrErr = 1'b0;
    bif.outReady = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    refresh();

    // 1. reset state, then idle with empty FIFO
    #3;
    chk("rst_valid", 32'(bif.outValid), 0);
    chk("rst_last",  32'(bif.outLast), 0);
    chk("rst_data",  bif.outData, 0);
    chk("rst_perr",  32'(parityErr), 0);
    chk("rst_ecnt",  32'(errCount), 0);
    #4 resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ren",  32'(bif.readEnable), 0);
      chk("idle_vld",  32'(bif.outValid), 0);
      chk("idle_ecnt", 32'(errCount), 0);
    end

    // 2. stream 32 words, two packets
    for (int k = 0; k < 32; k++) push(k, 4'h0);
    #1;
    for (int k = 0; k < 32; k++) begin
      chk("str_ren", 32'(bif.readEnable), 1);
      tick();
      chk("str_vld",  32'(bif.outValid), 1);
      chk("str_data", bif.outData, dat(k));
      chk("str_last", 32'(bif.outLast), 32'((k % 16) == 15));
    end
    tick();
    chk("str_end_vld", 32'(bif.outValid), 0);
    chk("str_perr", 32'(parityErr), 0);

    // 3. backpressure: exactly two pops, hold, then ordered drain
    for (int k = 32; k < 38; k++) push(k, 4'h0);
    bif.outReady = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_ren",  32'(bif.readEnable), 0);
      chk("bp_rd",   32'(rd), 34);
      chk("bp_hold", bif.outData, dat(32));
      tick();
    end
    bif.outReady = 1'b1;
    for (int k = 33; k < 38; k++) begin
      tick();
      chk("bp_data", bif.outData, dat(k));
      chk("bp_last", 32'(bif.outLast), 0);
    end
    tick();
    chk("bp_end_vld", 32'(bif.outValid), 0);

    // 4. parity: word 5 of this batch has DOP bit 33 flipped
    for (int j = 0; j < 8; j++) push(38 + j, (j == 5) ? 4'b0010 : 4'b0000);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("par_data", bif.outData, dat(38 + j));
      chk("par_flag", 32'(parityErr), 32'(j >= 5));
      chk("par_cnt",  32'(errCount), (j >= 5) ? 1 : 0);
    end
    tick();
    for (int k = 46; k < 346; k++) push(k, 4'b0001);
    for (int j = 0; j < 300; j++) begin
      tick();
      if (j == 252) chk("sat_254", 32'(errCount), 254);
      if (j == 253) chk("sat_255", 32'(errCount), 255);
    end
    tick();
    chk("sat_end", 32'(errCount), 255);
    chk("sat_flag", 32'(parityErr), 1);
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    chk("clr_flag", 32'(parityErr), 0);
    chk("clr_cnt",  32'(errCount), 0);
    push(346, 4'b0100);
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    chk("clrbad_flag", 32'(parityErr), 1);
    chk("clrbad_cnt",  32'(errCount), 1);
    chk("clrbad_data", bif.outData, dat(346));
    tick();

    // 5. flush with two buffered words at packet word 7
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 347; k < 374; k++) push(k, 4'h0);
    for (int j = 0; j < 6; j++) tick();
    chk("fl_pre_data", bif.outData, dat(352));
    bif.outReady = 1'b0;
    tick();
    chk("fl_two_ren", 32'(bif.readEnable), 0);
    flush = 1'b1;
    #1;
    chk("fl_ren", 32'(bif.readEnable), 0);
    tick();
    flush = 1'b0;
    chk("fl_vld", 32'(bif.outValid), 0);
    chk("fl_perr_kept", 32'(parityErr), 1);
    bif.outReady = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("fl_data", bif.outData, dat(354 + j));
      chk("fl_last", 32'(bif.outLast), 32'(j == 15));
    end
    for (int j = 0; j < 5; j++) tick();
    chk("fl_end_vld", 32'(bif.outValid), 0);

    // 6. asynchronous reset mid-stream
    for (int k = 374; k < 397; k++) push(k, (k == 375) ? 4'b1000 : 4'b0000);
    for (int j = 0; j < 3; j++) tick();
    chk("ar_pre_data", bif.outData, dat(376));
    chk("ar_pre_cnt",  32'(errCount), 2);
    #2 resetN = 1'b0;
    #1;
    chk("ar_ren",  32'(bif.readEnable), 0);
    chk("ar_vld",  32'(bif.outValid), 0);
    chk("ar_data", bif.outData, 0);
    chk("ar_perr", 32'(parityErr), 0);
    chk("ar_ecnt", 32'(errCount), 0);
    #2 resetN = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("ar_data2", bif.outData, dat(377 + j));
      chk("ar_last",  32'(bif.outLast), 32'(j == 15));
    end
    for (int j = 0; j < 5; j++) tick();
    chk("ar_end_vld", 32'(bif.outValid), 0);
    chk("ar_end_rd", 32'(rd), 397);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
